// File: rtl/event_encoder.sv
// Registered 8-to-3 event encoder. Event pulses on d are captured into a
// sticky pending register and presented one at a time, round-robin, as a
// 3-bit index s with a valid/ready handshake.
module event_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [7:0] d,
  input  logic       clr_ovf,
  output logic [2:0] s,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       ovf
);

  typedef enum logic {StIdle, StHold} state_e;

  state_e     r_state;
  state_e     w_state_next;

  logic [7:0] r_pending;
  logic [2:0] r_s;
  logic [2:0] r_ptr;
  logic       r_ovf;

  logic       w_accept;
  logic [7:0] w_set;
  logic [7:0] w_clr_mask;
  logic [7:0] w_pending_next;
  logic       w_ovf_set;
  logic       w_found;
  logic [2:0] w_sel;

  // Accept happens only while presenting; ready never reaches an output combinationally.
  assign w_accept   = (r_state == StHold) && ready;
  assign w_set      = e ? d : 8'h00;
  assign w_clr_mask = w_accept ? (8'h01 << r_s) : 8'h00;

  // Set wins over the accept-clear on the same bit.
  assign w_pending_next = (r_pending & ~w_clr_mask) | w_set;

  // A repeat request counts as overflow only if the bit is not being consumed this edge.
  assign w_ovf_set = |(w_set & r_pending & ~w_clr_mask);

  // Round-robin scan: first pending bit at or above the pointer, wrapping modulo 8.
  always_comb begin
    logic [2:0] w_idx;
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_found) w_state_next = StHold;
      StHold: if (ready)   w_state_next = StIdle;
      default:             w_state_next = StIdle;
    endcase
  end

  // Datapath registers: pending set, overflow flag, presented index, rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 8'h00;
      r_ovf     <= 1'b0;
      r_s       <= 3'd0;
      r_ptr     <= 3'd0;
    end else begin
      r_pending <= w_pending_next;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
      // s is loaded only from IDLE, so it stays frozen for the whole HOLD.
      if ((r_state == StIdle) && w_found) begin
        r_s <= w_sel;
      end
      if (w_accept) begin
        r_ptr <= r_s + 3'd1;
      end
    end
  end

  // FSM outputs.
  always_comb begin
    valid   = (r_state == StHold);
    s       = r_s;
    pending = r_pending;
    ovf     = r_ovf;
  end

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_event_encoder;

  logic       clk;
  logic       rst;
  logic       e;
  logic [7:0] d;
  logic       clr_ovf;
  logic [2:0] s;
  logic       valid;
  logic       ready;
  logic [7:0] pending;
  logic       ovf;

  int n_chk;
  int n_fail;

  // Behavioural model state.
  logic [7:0] m_pending;
  logic       m_valid;
  logic [2:0] m_s;
  logic       m_ovf;
  int         m_ptr;

  event_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .e       (e),
    .d       (d),
    .clr_ovf (clr_ovf),
    .s       (s),
    .valid   (valid),
    .ready   (ready),
    .pending (pending),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sticky event set, one presented index at a time, round-robin.
  always @(posedge clk or posedge rst) begin : model
    logic [7:0] nxt;
    logic       hit;
    logic       acc;
    int         idx;
    if (rst) begin
      m_pending <= 8'h00;
      m_valid   <= 1'b0;
      m_s       <= 3'd0;
      m_ovf     <= 1'b0;
      m_ptr     <= 0;
    end else begin
      acc = m_valid && ready;
      nxt = m_pending;
      hit = 1'b0;
      if (acc) nxt[m_s] = 1'b0;
      if (e) begin
        for (int i = 0; i < 8; i++) begin
          if (d[i]) begin
            if (m_pending[i] && !(acc && (int'(m_s) == i))) hit = 1'b1;
            nxt[i] = 1'b1;
          end
        end
      end
      m_pending <= nxt;
      if (hit) m_ovf <= 1'b1;
      else if (clr_ovf) m_ovf <= 1'b0;
      if (!m_valid) begin
        if (m_pending != 8'h00) begin
          idx = -1;
          for (int k = 0; k < 8; k++) begin
            if (idx < 0 && m_pending[(m_ptr + k) % 8]) idx = (m_ptr + k) % 8;
          end
          m_s     <= idx[2:0];
          m_valid <= 1'b1;
        end
      end else if (ready) begin
        m_valid <= 1'b0;
        m_ptr   <= (int'(m_s) + 1) % 8;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Compare all outputs against the model.
  task automatic cmp_model();
    chk("model.pending", pending, m_pending);
    chk("model.valid", {7'd0, valid}, {7'd0, m_valid});
    chk("model.ovf", {7'd0, ovf}, {7'd0, m_ovf});
    if (m_valid) chk("model.s", {5'd0, s}, {5'd0, m_s});
  endtask

  // Drive one cycle of inputs, then compare at the following falling edge.
  task automatic step(input logic ie, input logic [7:0] id, input logic irdy,
                      input logic iclr);
    e       = ie;
    d       = id;
    ready   = irdy;
    clr_ovf = iclr;
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    d   = 8'h00;
    @(negedge clk);
    cmp_model();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    e       = 1'b1;
    d       = 8'hFF;
    ready   = 1'b0;
    clr_ovf = 1'b0;

    // Reset held with all requests active.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.pending", pending, 8'h00);
      chk("rst.valid", {7'd0, valid}, 8'h00);
      chk("rst.s", {5'd0, s}, 8'h00);
      chk("rst.ovf", {7'd0, ovf}, 8'h00);
      cmp_model();
    end
    rst = 1'b0;

    // Single event.
    step(1'b1, 8'h20, 1'b1, 1'b0);
    chk("single.pending", pending, 8'h20);
    chk("single.valid0", {7'd0, valid}, 8'h00);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("single.valid", {7'd0, valid}, 8'h01);
    chk("single.s", {5'd0, s}, 8'd5);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("single.acc_pending", pending, 8'h00);
    chk("single.acc_valid", {7'd0, valid}, 8'h00);

    // Round-robin and wrap from a fresh pointer.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 8'h81, 1'b1, 1'b0);
      step(1'b1, 8'h00, 1'b1, 1'b0);
      chk("rr.first", {5'd0, s}, 8'd0);
      step(1'b1, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h00, 1'b1, 1'b0);
      chk("rr.second", {5'd0, s}, 8'd7);
      step(1'b1, 8'h00, 1'b1, 1'b0);
      chk("rr.drained", pending, 8'h00);
    end

    // Backpressure.
    step(1'b1, 8'h08, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("bp.s", {5'd0, s}, 8'd3);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("bp.hold_s", {5'd0, s}, 8'd3);
    chk("bp.hold_valid", {7'd0, valid}, 8'h01);
    chk("bp.pending", pending, 8'h18);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("bp.acc_pending", pending, 8'h10);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("bp.next_s", {5'd0, s}, 8'd4);
    step(1'b1, 8'h00, 1'b1, 1'b0);

    // Overflow, clear, and set-during-accept.
    step(1'b1, 8'h04, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("ovf.s", {5'd0, s}, 8'd2);
    chk("ovf.before", {7'd0, ovf}, 8'h00);
    step(1'b1, 8'h04, 1'b0, 1'b0);
    chk("ovf.set", {7'd0, ovf}, 8'h01);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    chk("ovf.clr", {7'd0, ovf}, 8'h00);
    step(1'b1, 8'h04, 1'b1, 1'b0);
    chk("ovf.acc_same_edge", {7'd0, ovf}, 8'h00);
    chk("ovf.acc_pending", pending, 8'h04);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);

    // Enable gating, then asynchronous reset mid-handshake.
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 1'b0, 1'b0);
    chk("gate.pending", pending, 8'h02);
    chk("gate.ovf", {7'd0, ovf}, 8'h00);
    chk("gate.valid", {7'd0, valid}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("async.valid", {7'd0, valid}, 8'h00);
    chk("async.pending", pending, 8'h00);
    cmp_model();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rd = 8'h00;
      for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) rd[b] = 1'b1;
      step(($urandom_range(3) != 0), rd, $urandom_range(1) == 1, $urandom_range(15) == 0);
      if ($urandom_range(399) == 0) begin
        #2 rst = 1'b1;
        #1 cmp_model();
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/event_encoder.md
# event_encoder

Registered 8-to-3 event encoder with a valid/ready output handshake. It is the encoding counterpart of the team's 3-to-8 enable decoder. Single-cycle event pulses on eight request lines are captured into a sticky pending register. Each pending event is presented as a 3-bit index, in round-robin order, until a downstream consumer accepts it. Typical placement: in front of a 3-to-8 decoder, or feeding an interrupt/event index to a controller.

## Interface
- No parameters. Widths are fixed: 8 request lines, 3-bit index.
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  asynchronous reset, active-high
- e  input  1  capture enable; 0 = ignore new requests (pending events are still served)
- d  input  8  event request pulses; d[i] requests index i
- clr_ovf  input  1  synchronous clear of the ovf flag
- s  output  3  encoded index of the event being presented
- valid  output  1  s holds a pending event
- ready  input  1  consumer accepts s when valid && ready at a rising edge
- pending  output  8  current pending register (observability)
- ovf  output  1  sticky flag: an event arrived on an already-pending line

## Operation
- Reset values (asynchronous, while rst=1): pending=8'h00, s=3'd0, valid=0, ovf=0, rr pointer=3'd0, FSM=IDLE.
- Capture:
  - At each edge with e=1, pending[i] is set for every d[i]=1.
  - With e=0, d is ignored entirely and neither pending nor ovf changes from d.
- Clear: on an accept edge (valid && ready), pending[s] is cleared.
- Simultaneous set and clear on the same bit at one edge: set wins and the bit stays 1. This is a new event, not an overflow.
- Overflow:
  - ovf sets at an edge where e=1, d[i]=1 and pending[i]=1, unless that same edge clears bit i by accept.
  - ovf clears at an edge with clr_ovf=1.
  - If clr_ovf and a new overflow occur at the same edge, set wins.
- FSM with two states:
  - IDLE (valid=0): if pending != 0, select the first set bit scanning upward from rr pointer (ptr, ptr+1, …, 7, 0, …, wrapping modulo 8). Load s with that index, set valid=1, go to HOLD. If pending == 0, stay in IDLE.
  - HOLD (valid=1): s is frozen. On ready=1: clear pending[s], set valid=0, set rr pointer = s+1 (mod 8, so 7 wraps to 0), go to IDLE. On ready=0: stay in HOLD.
- Selection uses the pending register value at the edge. Requests captured at that same edge are not visible to the scan until the next cycle.
- Once valid=1, s and valid must not change until accepted. The consumer may hold ready high continuously.

## Timing
- Latency: d[i] pulse at edge N gives pending[i]=1 after N. With the FSM in IDLE, valid=1 and s=i after edge N+1.
- Throughput: at most one accepted event every 2 cycles (HOLD then IDLE).
- The ready→valid deassert is registered: valid falls at the accept edge.
- ready has no combinational path to any output.
- d and e are sampled only at rising edges; glitches between edges have no effect.
- Reset asserted mid-handshake drops valid immediately (asynchronously) and discards all pending events and ovf.
- After rst deasserts, the first capture occurs at the first rising edge.

## Test plan
- Reset with d=8'hFF, e=1, rst held high → pending=0, valid=0, s=0, ovf=0 throughout reset.
- Single event: pulse d=8'h20 with e=1, ready=1 → pending=8'h20, next edge valid=1 and s=5, next edge accept → pending=0, valid=0.
- Round-robin and wrap:
  - Pulse d=8'h81, ready=1 → s=0 accepted first, then s=7.
  - Then pulse d=8'h81 again → s=0 is served (pointer wrapped 7→0), then s=7.
- Backpressure: valid=1, s=3, ready=0 for 5 cycles while d=8'h10 pulses → s stays 3, pending=8'h18. Raising ready accepts 3, then s=4.
- Overflow:
  - Pulse d[2] twice while it is pending → ovf=1.
  - Pulse d[2] at the exact edge it is accepted → ovf stays 0 and pending[2] stays 1.
  - clr_ovf=1 → ovf=0.
- Enable gating: e=0, d=8'hFF for 3 cycles → pending unchanged and no ovf. Reset asserted while valid=1 → valid=0 immediately, pending=0.
